// File: rtl/lsu_mem_ctrl_if.sv
// Load/store unit bus bundle: request, response and physical-memory port.
// The controller sits on the slave side; the requester/memory on the master.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_wen;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic        resp_err;
   logic [63:0] mem_raddr;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;

   modport slave (
      input  req_valid, req_addr, req_wen, req_size,
      input  req_unsigned, req_wdata, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_err,
      output mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_wmask
   );

   modport master (
      output req_valid, req_addr, req_wen, req_size,
      output req_unsigned, req_wdata, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_err,
      input  mem_raddr, mem_rvalid, mem_waddr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request at a time, one memory cycle per access,
// byte-lane alignment and load extension, misaligned requests rejected.
module lsu_mem_ctrl (
   input  logic          clock,
   input  logic          reset,
   lsu_mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic        wen_q, wen_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_data_q, resp_data_d;
   logic        resp_err_q, resp_err_d;

   logic        in_acc;
   logic        misal;
   logic [2:0]  off;
   logic [5:0]  sh;
   logic [7:0]  lane_mask;
   logic [63:0] rshift;
   logic [63:0] ld_ext;

   assign in_acc = (state_q == ACCESS);
   assign off    = addr_q[2:0];
   assign sh     = {off, 3'b000};
   assign rshift = bus.mem_rdata >> sh;

   // Alignment check, lane mask and load extension for the latched request
   always_comb begin
      misal     = 1'b0;
      lane_mask = 8'h00;
      ld_ext    = 64'd0;
      unique case (size_q)
         2'd0: begin
            misal     = 1'b0;
            lane_mask = 8'h01 << off;
            ld_ext    = {{56{rshift[7] & ~uns_q}}, rshift[7:0]};
         end
         2'd1: begin
            misal     = addr_q[0];
            lane_mask = 8'h03 << off;
            ld_ext    = {{48{rshift[15] & ~uns_q}}, rshift[15:0]};
         end
         2'd2: begin
            misal     = |addr_q[1:0];
            lane_mask = 8'h0F << off;
            ld_ext    = {{32{rshift[31] & ~uns_q}}, rshift[31:0]};
         end
         default: begin
            misal     = |addr_q[2:0];
            lane_mask = 8'hFF;
            ld_ext    = rshift;
         end
      endcase
   end

   // Memory port: driven only in ACCESS, strobes killed while in reset
   always_comb begin
      bus.mem_raddr  = 64'd0;
      bus.mem_rvalid = 1'b0;
      bus.mem_waddr  = 64'd0;
      bus.mem_wdata  = 64'd0;
      bus.mem_wmask  = 8'h00;
      if (in_acc && !wen_q) begin
         bus.mem_raddr  = {addr_q[63:3], 3'b000};
         bus.mem_rvalid = !misal && !reset;
      end
      if (in_acc && wen_q) begin
         bus.mem_waddr = {addr_q[63:3], 3'b000};
         bus.mem_wdata = wdata_q << sh;
         if (!misal && !reset) begin
            bus.mem_wmask = lane_mask;
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && !reset;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_err   = resp_err_q;

   // Next-state and register updates for IDLE -> ACCESS -> RESP
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wen_d        = wen_q;
      size_d       = size_q;
      uns_d        = uns_q;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wen_d   = bus.req_wen;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            resp_valid_d = 1'b1;
            resp_err_d   = misal;
            resp_data_d  = (misal || wen_q) ? 64'd0 : ld_ext;
            state_d      = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         wen_q        <= 1'b0;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= 64'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wen_q        <= wen_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
      end
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store initiator between the execute stage and the DPI physical-memory port. It accepts one load or store request at a time over a valid/ready handshake and drives the memory port for exactly one cycle per access. It aligns addresses to 8 bytes, generates byte masks, shifts store data into its lanes, and extracts and sign/zero-extends load data. Results go back to write-back over a second valid/ready handshake; misaligned requests are rejected without touching memory.

## Interface
- No parameters. Data and address widths are fixed at 64.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  64  byte address.
- req_wen  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  result present.
- resp_ready  in  1  write-back accepts the result.
- resp_data  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access.
- mem_raddr  out  64  read address, 8-byte aligned.
- mem_rvalid  out  1  read strobe.
- mem_rdata  in  64  read data, combinational from memory in the same cycle as mem_rvalid.
- mem_waddr  out  64  write address, 8-byte aligned.
- mem_wdata  out  64  lane-shifted store data.
- mem_wmask  out  8  byte-lane write mask. Memory writes whenever this is nonzero.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - req_ready = 1.
  - When req_valid is high, latch addr/wen/size/unsigned/wdata into registers and go to ACCESS.
- ACCESS (exactly 1 cycle)
  - Memory port is driven only from the latched registers.
  - Misaligned is defined as addr mod 2^size ≠ 0. If misaligned: mem_rvalid = 0, mem_wmask = 0, and err is latched as 1.
  - Aligned load:
    - mem_raddr = {addr[63:3], 3'b0}, mem_rvalid = 1.
    - Compute rdata >> (addr[2:0]*8), truncate to 8·2^size bits, extend per req_unsigned, and latch the result.
  - Aligned store:
    - mem_waddr = aligned address.
    - mem_wdata = wdata << (addr[2:0]*8).
    - mem_wmask = ((1 << 2^size) − 1) << addr[2:0].
    - Latched result data = 0.
  - Always go to RESP.
- RESP
  - resp_valid = 1. resp_data and resp_err are held stable.
  - When resp_ready is high, go to IDLE.
  - req_ready = 0; no request is accepted in the same cycle (no bypass).
- Outside ACCESS: mem_rvalid = 0, mem_wmask = 0, and mem_raddr/mem_waddr/mem_wdata = 0.
- Double-word access with addr[2:0] = 0 passes data unchanged; the mask is 0xFF.

## Timing
- Request handshake at edge N. Memory access occurs in cycle N+1. resp_valid rises in cycle N+2.
- Minimum request-to-request spacing is 3 cycles, with resp_ready tied high.
- resp_valid stays high and resp_data/resp_err stay constant until the resp_ready handshake.
- Reset values:
  - State = IDLE.
  - req_ready = 1 after reset deasserts.
  - resp_valid = 0, resp_data = 0, resp_err = 0.
  - All mem_* outputs = 0.
- While reset is high:
  - mem_rvalid and mem_wmask are forced to 0 combinationally, so no memory access or write happens in the reset cycle, even mid-ACCESS.
  - req_ready = 0.
- Reset in RESP discards the pending result with no handshake.
- A request presented during reset is ignored.

## Test plan
- Signed byte load:
  - Stimulus: memory at 0x80000000 holds 0x1122_3344_5566_8877; load byte, signed, addr 0x80000001.
  - Required: mem_raddr 0x80000000 in cycle N+1; resp_data 0xFFFF_FFFF_FFFF_FF88 at N+2; resp_err 0.
- Unsigned half load:
  - Stimulus: same memory word; load half, unsigned, addr 0x80000006.
  - Required: resp_data 0x1122.
- Word store:
  - Stimulus: word store, addr 0x80000004, wdata 0xDEADBEEF.
  - Required: one ACCESS cycle with mem_waddr 0x80000000, mem_wdata 0xDEADBEEF_0000_0000, mem_wmask 0xF0; a following double load returns 0xDEADBEEF_5566_8877.
- Misaligned access:
  - Stimulus: word load at 0x80000002, and a double store at 0x80000004.
  - Required: mem_rvalid and mem_wmask stay 0 throughout; resp_err = 1; resp_data = 0; latency unchanged.
- Backpressure:
  - Stimulus: resp_ready held low for 5 cycles; req_valid held high with a second request.
  - Required: resp_valid and resp_data stable for all 5 cycles; req_ready = 0; the second request is accepted only on the cycle after the response handshake; exactly one memory access per request.
- Reset during ACCESS:
  - Stimulus: reset asserted in the store's ACCESS cycle.
  - Required: mem_wmask = 0 in that cycle; memory unchanged; all outputs at reset values on the next cycle.
